// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-stage program-counter sequencer.
//   - default reset / interrupt / exception vectors (32-bit; narrowed by users)
//   - default sequential increment
//   - next-PC source enum and a helper classifying redirecting sources
package pc_seq_pkg;

  localparam logic [31:0] DEF_RESET_PC    = 32'h8000_0000;
  localparam logic [31:0] DEF_IRQ_VECTOR  = 32'h8000_0004;
  localparam logic [31:0] DEF_EXC_VECTOR  = 32'h8000_0008;
  localparam int          DEF_INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_HOLD,
    SRC_JMP,
    SRC_BR,
    SRC_ERET,
    SRC_IRQ,
    SRC_EXC
  } pc_src_e;

  // Any source other than sequential advance or hold breaks the fetch stream.
  function automatic logic is_redirect(pc_src_e src);
    return !(src == SRC_SEQ || src == SRC_HOLD);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selector.
// Encodes the redirect priority: exception, interrupt, eret, branch, jump,
// hold, sequential.
// Ports:
//   pc_i, pc_plus_i        current PC and its sequential successor
//   hold_i                 fetch stall
//   br_valid_i/br_target_i taken branch from EX
//   jmp_valid_i/jmp_target_i jump from ID
//   exc_valid_i            exception from ID
//   eret_i                 return-from-exception from ID
//   kernel_i, irq_pend_i, epc_i  architectural state feeding the decision
//   src_o                  chosen next-PC source
//   next_pc_o              PC to load on the next edge
//   fall_pc_o              PC the lower-priority sources (eret..seq) would
//                          produce; saved as EPC when an interrupt is taken
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] IRQ_VECTOR = WIDTH'(DEF_IRQ_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] pc_plus_i,
  input  logic             hold_i,
  input  logic             br_valid_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  logic             jmp_valid_i,
  input  logic [WIDTH-1:0] jmp_target_i,
  input  logic             exc_valid_i,
  input  logic             eret_i,
  input  logic             kernel_i,
  input  logic             irq_pend_i,
  input  logic [WIDTH-1:0] epc_i,
  output pc_src_e          src_o,
  output logic [WIDTH-1:0] next_pc_o,
  output logic [WIDTH-1:0] fall_pc_o
);

  pc_src_e fall_src;

  always_comb begin
    // Lower-priority choice first; it doubles as the interrupt return address.
    fall_src  = SRC_SEQ;
    fall_pc_o = pc_plus_i;
    if (eret_i && kernel_i) begin
      fall_src  = SRC_ERET;
      fall_pc_o = epc_i;
    end else if (br_valid_i) begin
      // Branch comes from the older instruction in EX, so it beats hold and jump.
      fall_src  = SRC_BR;
      fall_pc_o = br_target_i;
    end else if (jmp_valid_i && !hold_i) begin
      // A stalled ID re-presents the jump, so it is dropped under hold.
      fall_src  = SRC_JMP;
      fall_pc_o = jmp_target_i;
    end else if (hold_i) begin
      fall_src  = SRC_HOLD;
      fall_pc_o = pc_i;
    end

    src_o     = fall_src;
    next_pc_o = fall_pc_o;
    if (exc_valid_i) begin
      src_o     = SRC_EXC;
      next_pc_o = EXC_VECTOR;
    end else if (irq_pend_i && !kernel_i && !hold_i) begin
      src_o     = SRC_IRQ;
      next_pc_o = IRQ_VECTOR;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Holds the PC, kernel-mode bit, exception PC, latched interrupt-pending flag
// and a one-cycle redirect indication for the hazard unit.
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   hold                   fetch stall
//   br_valid/br_target     taken branch (EX)
//   jmp_valid/jmp_target   jump (ID)
//   exc_valid/exc_pc       illegal instruction and its PC (ID)
//   eret                   return-from-exception (ID)
//   irq                    level interrupt request
//   pc_o, pc_plus_o        fetch address and its sequential successor
//   kernel_o, epc_o        kernel-mode flag and saved return address
//   irq_pend_o             interrupt latched but not yet taken
//   redirect_o             one cycle high after any non-sequential update
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(DEF_RESET_PC),
  parameter logic [WIDTH-1:0] IRQ_VECTOR  = WIDTH'(DEF_IRQ_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(DEF_EXC_VECTOR),
  parameter int               INSTR_BYTES = DEF_INSTR_BYTES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             br_valid,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp_valid,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             exc_valid,
  input  logic [WIDTH-1:0] exc_pc,
  input  logic             eret,
  input  logic             irq,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             kernel_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             irq_pend_o,
  output logic             redirect_o
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             kernel_q, kernel_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             irq_pend_q, irq_pend_d;
  logic             redirect_q, redirect_d;

  pc_src_e          src;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] fall_pc;

  // Wraps modulo 2^WIDTH by construction.
  assign pc_plus_o = pc_q + WIDTH'(INSTR_BYTES);

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .IRQ_VECTOR (IRQ_VECTOR),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_sel (
    .pc_i         (pc_q),
    .pc_plus_i    (pc_plus_o),
    .hold_i       (hold),
    .br_valid_i   (br_valid),
    .br_target_i  (br_target),
    .jmp_valid_i  (jmp_valid),
    .jmp_target_i (jmp_target),
    .exc_valid_i  (exc_valid),
    .eret_i       (eret),
    .kernel_i     (kernel_q),
    .irq_pend_i   (irq_pend_q),
    .epc_i        (epc_q),
    .src_o        (src),
    .next_pc_o    (next_pc),
    .fall_pc_o    (fall_pc)
  );

  always_comb begin
    pc_d       = next_pc;
    kernel_d   = kernel_q;
    epc_d      = epc_q;
    redirect_d = is_redirect(src);
    // A still-high irq on the taking edge re-pends the interrupt.
    irq_pend_d = irq || (irq_pend_q && (src != SRC_IRQ));
    case (src)
      SRC_EXC: begin
        kernel_d = 1'b1;
        epc_d    = exc_pc;
      end
      SRC_IRQ: begin
        kernel_d = 1'b1;
        epc_d    = fall_pc;
      end
      SRC_ERET: kernel_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      kernel_q   <= 1'b1;
      epc_q      <= '0;
      irq_pend_q <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      kernel_q   <= kernel_d;
      epc_q      <= epc_d;
      irq_pend_q <= irq_pend_d;
      redirect_q <= redirect_d;
    end
  end

  assign pc_o       = pc_q;
  assign kernel_o   = kernel_q;
  assign epc_o      = epc_q;
  assign irq_pend_o = irq_pend_q;
  assign redirect_o = redirect_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table on a 32-bit instance,
// hand sequence on an 8-bit instance, randomized run against a model.
module tb_pc_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- 32-bit DUT ----------------
  logic        rst, hold, br, jmp, exc, eret, irq;
  logic [31:0] brt, jt, ep;
  logic [31:0] pc, pc_plus, epc;
  logic        kern, pend, redir;

  pc_sequencer dut (
    .clk(clk), .reset(rst), .hold(hold),
    .br_valid(br), .br_target(brt),
    .jmp_valid(jmp), .jmp_target(jt),
    .exc_valid(exc), .exc_pc(ep),
    .eret(eret), .irq(irq),
    .pc_o(pc), .pc_plus_o(pc_plus), .kernel_o(kern),
    .epc_o(epc), .irq_pend_o(pend), .redirect_o(redir)
  );

  // ---------------- 8-bit DUT ----------------
  logic       rst8, hold8, br8, jmp8, exc8, eret8, irq8;
  logic [7:0] brt8, jt8, ep8;
  logic [7:0] pc8, pc_plus8, epc8;
  logic       kern8, pend8, redir8;

  pc_sequencer #(
    .WIDTH(8), .RESET_PC(8'hFC), .IRQ_VECTOR(8'h04),
    .EXC_VECTOR(8'h08), .INSTR_BYTES(4)
  ) dut8 (
    .clk(clk), .reset(rst8), .hold(hold8),
    .br_valid(br8), .br_target(brt8),
    .jmp_valid(jmp8), .jmp_target(jt8),
    .exc_valid(exc8), .exc_pc(ep8),
    .eret(eret8), .irq(irq8),
    .pc_o(pc8), .pc_plus_o(pc_plus8), .kernel_o(kern8),
    .epc_o(epc8), .irq_pend_o(pend8), .redirect_o(redir8)
  );

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst, hold, br;
    logic [31:0] brt;
    logic        jmp;
    logic [31:0] jt;
    logic        exc;
    logic [31:0] ep;
    logic        eret, irq;
    logic [31:0] e_pc;
    logic        e_k;
    logic [31:0] e_epc;
    logic        e_p, e_r;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic r, logic h, logic b, logic [31:0] bt, logic j, logic [31:0] t,
    logic x, logic [31:0] xp, logic er, logic iq,
    logic [31:0] epc_v, logic k, logic [31:0] e, logic p, logic rd);
    vec_t v;
    v.rst = r; v.hold = h; v.br = b; v.brt = bt; v.jmp = j; v.jt = t;
    v.exc = x; v.ep = xp; v.eret = er; v.irq = iq;
    v.e_pc = epc_v; v.e_k = k; v.e_epc = e; v.e_p = p; v.e_r = rd;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_idle();
    rst = 0; hold = 0; br = 0; brt = '0; jmp = 0; jt = '0;
    exc = 0; ep = '0; eret = 0; irq = 0;
  endtask

  task automatic drive8(input logic r, input logic e, input logic i);
    rst8 = r; eret8 = e; irq8 = i;
    hold8 = 0; br8 = 0; brt8 = '0; jmp8 = 0; jt8 = '0; exc8 = 0; ep8 = '0;
  endtask

  task automatic check8(input int idx, input logic [7:0] e_pc, input logic e_k,
                        input logic [7:0] e_epc, input logic e_p, input logic e_r);
    string s;
    s = $sformatf("w8[%0d]", idx);
    chk({s, ".pc"},       {24'd0, pc8},       {24'd0, e_pc});
    chk({s, ".pc_plus"},  {24'd0, pc_plus8},  {24'd0, e_pc + 8'd4});
    chk({s, ".kernel"},   {31'd0, kern8},     {31'd0, e_k});
    chk({s, ".epc"},      {24'd0, epc8},      {24'd0, e_epc});
    chk({s, ".irq_pend"}, {31'd0, pend8},     {31'd0, e_p});
    chk({s, ".redirect"}, {31'd0, redir8},    {31'd0, e_r});
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc, m_epc;
  logic        m_k, m_p, m_r;
  logic [31:0] exp_q[$];

  // One architectural step from the rule list: exception beats interrupt;
  // otherwise the "normal" outcome is worked out and an interrupt may
  // steal it, saving that outcome as the return address.
  task automatic model_step();
    logic [31:0] normal;
    logic        normal_redir;
    logic        leave_kernel;
    logic        taken_irq;
    if (rst) begin
      m_pc = 32'h8000_0000; m_k = 1; m_epc = 0; m_p = 0; m_r = 0;
      return;
    end
    leave_kernel = 0;
    normal_redir = 1;
    if (eret && m_k) begin normal = m_epc; leave_kernel = 1; end
    else if (br)            normal = brt;
    else if (jmp && !hold)  normal = jt;
    else begin
      normal_redir = 0;
      normal = hold ? m_pc : m_pc + 32'd4;
    end
    taken_irq = 0;
    if (exc) begin
      m_pc = 32'h8000_0008; m_epc = ep; m_k = 1; m_r = 1;
    end else if (m_p && !m_k && !hold) begin
      m_epc = normal; m_pc = 32'h8000_0004; m_k = 1; m_r = 1; taken_irq = 1;
    end else begin
      m_pc = normal; m_r = normal_redir;
      if (leave_kernel) m_k = 0;
    end
    m_p = irq | (m_p & ~taken_irq);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_idle();
    drive8(1, 0, 0);

    // Directed table on the 32-bit instance.
    //         rst h  br brt           jmp jt            exc ep        eret irq  pc            k  epc           p  r
    vecs.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_0000, 1, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_0004, 1, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_0008, 1, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_000C, 1, 0,            0, 0));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_0010, 1, 0,            0, 0));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_0010, 1, 0,            0, 0));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_0010, 1, 0,            0, 0));
    vecs.push_back(mk(0, 1, 1, 32'h8000_0100,0, 0,            0, 0,       0, 0, 32'h8000_0100, 1, 0,            0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_0104, 1, 0,            0, 0));
    // leave kernel mode via eret (epc is 0 after reset)
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       1, 0, 32'h0000_0000, 0, 0,            0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            1, 32'h3C,       0, 0,       0, 0, 32'h0000_003C, 0, 0,            0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 1, 32'h0000_0040, 0, 0,            1, 0));
    // interrupt taken together with a branch: branch target saved
    vecs.push_back(mk(0, 0, 1, 32'h200,      0, 0,            0, 0,       0, 0, 32'h8000_0004, 1, 32'h200,      0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       1, 0, 32'h0000_0200, 0, 32'h200,      0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 1, 32'h0000_0204, 0, 32'h200,      1, 0));
    // exception with an interrupt pending: interrupt stays pending
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h50,  0, 0, 32'h8000_0008, 1, 32'h50,       1, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       1, 0, 32'h0000_0050, 0, 32'h50,       1, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 0, 32'h8000_0004, 1, 32'h54,       0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       1, 0, 32'h0000_0054, 0, 32'h54,       0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            1, 32'h20,       0, 0,       0, 0, 32'h0000_0020, 0, 32'h54,       0, 1));
    // eret in user mode is ignored
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       1, 0, 32'h0000_0024, 0, 32'h54,       0, 0));
    // pending interrupt deferred by hold
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 1, 32'h0000_0028, 0, 32'h54,       1, 0));
    vecs.push_back(mk(0, 1, 0, 0,            1, 32'h500,      0, 0,       0, 0, 32'h0000_0028, 0, 32'h54,       1, 0));
    // branch+jump simultaneous while interrupt taken: branch address saved
    vecs.push_back(mk(0, 0, 1, 32'h300,      1, 32'h400,      0, 0,       0, 0, 32'h8000_0004, 1, 32'h300,      0, 1));
    // interrupt masked in kernel mode; exception in kernel overwrites epc
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 1, 32'h8000_0008, 1, 32'h300,      1, 0));
    vecs.push_back(mk(0, 1, 0, 0,            0, 0,            1, 32'h70,  0, 1, 32'h8000_0008, 1, 32'h70,       1, 1));
    // reset mid-handler and mid-stall
    vecs.push_back(mk(1, 1, 1, 32'h900,      0, 0,            0, 0,       0, 1, 32'h8000_0000, 1, 0,            0, 0));
    // wrap-around
    vecs.push_back(mk(0, 0, 0, 0,            1, 32'hFFFF_FFFC,0, 0,       0, 0, 32'hFFFF_FFFC, 1, 0,            0, 1));
    vecs.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,       0, 0, 32'h0000_0000, 1, 0,            0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      string s;
      rst = vecs[i].rst; hold = vecs[i].hold; br = vecs[i].br; brt = vecs[i].brt;
      jmp = vecs[i].jmp; jt = vecs[i].jt; exc = vecs[i].exc; ep = vecs[i].ep;
      eret = vecs[i].eret; irq = vecs[i].irq;
      @(posedge clk); #1;
      s = $sformatf("vec[%0d]", i);
      chk({s, ".pc"},       pc,             vecs[i].e_pc);
      chk({s, ".pc_plus"},  pc_plus,        vecs[i].e_pc + 32'd4);
      chk({s, ".kernel"},   {31'd0, kern},  {31'd0, vecs[i].e_k});
      chk({s, ".epc"},      epc,            vecs[i].e_epc);
      chk({s, ".irq_pend"}, {31'd0, pend},  {31'd0, vecs[i].e_p});
      chk({s, ".redirect"}, {31'd0, redir}, {31'd0, vecs[i].e_r});
    end

    // Hand sequence on the 8-bit instance: wrap after reset, interrupt,
    // then reset in the middle of the handler.
    drive8(1, 0, 0); @(posedge clk); #1; check8(0, 8'hFC, 1, 8'h00, 0, 0);
    drive8(0, 0, 0); @(posedge clk); #1; check8(1, 8'h00, 1, 8'h00, 0, 0);
    drive8(0, 1, 0); @(posedge clk); #1; check8(2, 8'h00, 0, 8'h00, 0, 1);
    drive8(0, 0, 1); @(posedge clk); #1; check8(3, 8'h04, 0, 8'h00, 1, 0);
    drive8(0, 0, 0); @(posedge clk); #1; check8(4, 8'h04, 1, 8'h08, 0, 1);
    drive8(1, 0, 0); @(posedge clk); #1; check8(5, 8'hFC, 1, 8'h00, 0, 0);

    // Randomized run against the model; first cycle forces reset to align.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] exp_pc;
      rst  = (n == 0) || ($urandom_range(0, 99) == 0);
      hold = ($urandom_range(0, 3) == 0);
      br   = ($urandom_range(0, 7) == 0);
      brt  = $urandom();
      jmp  = ($urandom_range(0, 7) == 0);
      jt   = $urandom();
      exc  = ($urandom_range(0, 15) == 0);
      ep   = $urandom();
      eret = ($urandom_range(0, 5) == 0);
      irq  = ($urandom_range(0, 4) == 0);
      model_step();
      exp_q.push_back(m_pc);
      @(posedge clk); #1;
      exp_pc = exp_q.pop_front();
      chk("rnd.pc",       pc,             exp_pc);
      chk("rnd.pc_plus",  pc_plus,        exp_pc + 32'd4);
      chk("rnd.kernel",   {31'd0, kern},  {31'd0, m_k});
      chk("rnd.epc",      epc,            m_epc);
      chk("rnd.irq_pend", {31'd0, pend},  {31'd0, m_p});
      chk("rnd.redirect", {31'd0, redir}, {31'd0, m_r});
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
